niosii_test_pio_capture: RTL and testbench

NIOSII_TEST_PIO_CAPTURE -- requirements
Module: niosii_test_pio_capture

---
 rtl/niosii_test_pio_capture.sv | 132 +++++++++++++
 tb/tb_niosii_test_pio_capture.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_test_pio_capture.sv
// Avalon-MM capture PIO: synchronized live inputs, coherent multi-channel snapshot, and an
// optional edge-capture interrupt enabled by defining NIOSII_TEST_PIO_CAPTURE_IRQ_EN.
module niosii_test_pio_capture #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_CHANNELS = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [3:0]                         address,
    input  logic                               chipselect,
    input  logic                               write_n,
    input  logic [31:0]                        writedata,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_port,
    output logic [31:0]                        readdata,
    output logic                               irq
);
    localparam int unsigned IN_W          = NUM_CHANNELS * DATA_WIDTH;
    localparam logic [3:0]  ADDR_CONTROL  = 4'h8;
    localparam logic [3:0]  ADDR_STATUS   = 4'h9;
    localparam logic [3:0]  ADDR_IRQ_MASK = 4'hA;
    localparam logic [3:0]  ADDR_EDGE     = 4'hB;

    logic [IN_W-1:0]         sync1;
    logic [IN_W-1:0]         live;
    logic [DATA_WIDTH-1:0]   snap [NUM_CHANNELS];
    logic                    status_valid;
    logic                    status_overrun;
    logic [NUM_CHANNELS-1:0] irq_mask_q;
    logic [NUM_CHANNELS-1:0] edge_cap_q;
    logic                    wr_c;
    logic                    trigger_c;
    logic [31:0]             rd_c;
    logic                    unused_c;

    assign wr_c      = chipselect & ~write_n;
    assign trigger_c = wr_c && (address == ADDR_CONTROL) && writedata[0];
    assign unused_c  = ^writedata[31:2];

    // Two-flop synchronizer; second stage is the live value seen by software.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            live  <= '0;
        end else begin
            sync1 <= in_port;
            live  <= sync1;
        end
    end

    // Snapshot of every channel on one edge; trigger and STATUS W1C use distinct addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) snap[ch] <= '0;
            status_valid   <= 1'b0;
            status_overrun <= 1'b0;
        end else if (trigger_c) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++)
                snap[ch] <= live[ch*DATA_WIDTH +: DATA_WIDTH];
            status_valid <= 1'b1;
            if (status_valid) status_overrun <= 1'b1;
        end else if (wr_c && (address == ADDR_STATUS)) begin
            if (writedata[0]) status_valid   <= 1'b0;
            if (writedata[1]) status_overrun <= 1'b0;
        end
    end

`ifdef NIOSII_TEST_PIO_CAPTURE_IRQ_EN
    logic [IN_W-1:0]         prev;
    logic [1:0]              fill_cnt;
    logic [NUM_CHANNELS-1:0] change_c;
    logic [NUM_CHANNELS-1:0] edge_clr_c;

    always_comb begin
        change_c   = '0;
        edge_clr_c = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++)
            change_c[ch] = (live[ch*DATA_WIDTH +: DATA_WIDTH] != prev[ch*DATA_WIDTH +: DATA_WIDTH]);
        if (wr_c && (address == ADDR_EDGE)) edge_clr_c = writedata[NUM_CHANNELS-1:0];
    end

    // fill_cnt masks the synchronizer refill after reset; new edges win over W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= '0;
            fill_cnt   <= 2'd0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            irq        <= 1'b0;
        end else begin
            prev <= live;
            if (fill_cnt != 2'd3) fill_cnt <= fill_cnt + 2'd1;
            if (wr_c && (address == ADDR_IRQ_MASK)) irq_mask_q <= writedata[NUM_CHANNELS-1:0];
            edge_cap_q <= (edge_cap_q & ~edge_clr_c) | ((fill_cnt == 2'd3) ? change_c : '0);
            irq        <= |(edge_cap_q & irq_mask_q);
        end
    end
`else
    assign irq_mask_q = '0;
    assign edge_cap_q = '0;
    assign irq        = 1'b0;
`endif

    // Read mux; absent channels and unmapped addresses return zero.
    always_comb begin
        rd_c = '0;
        case (address[3:2])
            2'b00: begin
                for (int ch = 0; ch < NUM_CHANNELS; ch++)
                    if (address[1:0] == 2'(ch)) rd_c = 32'(live[ch*DATA_WIDTH +: DATA_WIDTH]);
            end
            2'b01: begin
                for (int ch = 0; ch < NUM_CHANNELS; ch++)
                    if (address[1:0] == 2'(ch)) rd_c = 32'(snap[ch]);
            end
            2'b10: begin
                case (address[1:0])
                    2'd1:    rd_c = {30'd0, status_overrun, status_valid};
                    2'd2:    rd_c = 32'(irq_mask_q);
                    2'd3:    rd_c = 32'(edge_cap_q);
                    default: rd_c = '0;
                endcase
            end
            default: rd_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_c;
    end

endmodule

// File: tb/tb_niosii_test_pio_capture.sv
// Scoreboard bench for niosii_test_pio_capture: a 2x32 instance and a 1x8 instance share the bus.
module tb_niosii_test_pio_capture;
`ifdef NIOSII_TEST_PIO_CAPTURE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [63:0] in_port0;
    logic [7:0]  in_port1;
    logic [31:0] readdata0;
    logic [31:0] readdata1;
    logic        irq0;
    logic        irq1;

    niosii_test_pio_capture #(.DATA_WIDTH(32), .NUM_CHANNELS(2)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port0),
        .readdata(readdata0), .irq(irq0)
    );

    niosii_test_pio_capture #(.DATA_WIDTH(8), .NUM_CHANNELS(1)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port1),
        .readdata(readdata1), .irq(irq1)
    );

    always #5 clk = ~clk;

    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          due_q[$];
    int          kind_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];

    function automatic logic [31:0] ie(logic [31:0] v);
        return IRQ_EN ? v : 32'h0;
    endfunction

    // kind 0: dut0 readdata, 1: dut1 readdata, 2: dut0 irq
    task automatic expect_at(int ofs, int kind, logic [31:0] exp, string name);
        due_q.push_back(cyc + ofs);
        kind_q.push_back(kind);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic drive(logic cs, logic wn, logic [3:0] a, logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b1, 4'hC, 32'h0);
    endtask

    task automatic bus_write(logic [3:0] a, logic [31:0] d);
        drive(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(logic [3:0] a, logic [31:0] exp, string name);
        expect_at(1, 0, exp, name);
        drive(1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic rd1(logic [3:0] a, logic [31:0] exp, string name);
        expect_at(1, 1, exp, name);
        drive(1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic exp_irq(int ofs, logic v, string name);
        expect_at(ofs, 2, {31'd0, v}, name);
    endtask

    // Monitor: after every rising edge, check all expectations due on this cycle.
    initial begin
        logic [31:0] act;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = due_q.size() - 1; i >= 0; i--) begin
                if (due_q[i] == cyc) begin
                    case (kind_q[i])
                        0:       act = readdata0;
                        1:       act = readdata1;
                        default: act = {31'd0, irq0};
                    endcase
                    n_tests++;
                    if (act !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                                 name_q[i], act, exp_q[i], cyc);
                    end
                    due_q.delete(i);
                    kind_q.delete(i);
                    exp_q.delete(i);
                    name_q.delete(i);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 4'h0;
        writedata  = 32'h0;
        in_port0   = {32'h0000CAFE, 32'h12345678};
        in_port1   = 8'hA5;
        @(negedge clk);
        idle(3);
        reset = 1'b0;
        idle(5);

        // Post-reset state, live reads, synchronizer fill produces no edge
        exp_irq(1, 1'b0, "irq_after_reset");
        rd(4'h0, 32'h12345678, "live_ch0");
        rd(4'h1, 32'h0000CAFE, "live_ch1");
        rd(4'h2, 32'h0, "live_ch2_absent");
        rd(4'h4, 32'h0, "snap0_reset");
        rd(4'h9, 32'h0, "status_reset");
        rd(4'hA, 32'h0, "irq_mask_reset");
        rd(4'hB, 32'h0, "edge_fill_suppressed");
        rd(4'hC, 32'h0, "unmapped_0xc");
        rd1(4'h0, 32'h000000A5, "n1_live_ch0_zero_ext");
        rd1(4'h1, 32'h0, "n1_live_ch1_absent");

        // Writes to read-only registers are ignored
        bus_write(4'h0, 32'hFFFF_FFFF);
        bus_write(4'h4, 32'hFFFF_FFFF);
        rd(4'h0, 32'h12345678, "live_ro");
        rd(4'h4, 32'h0, "snap_ro");

        // Trigger, then inputs change on the next cycle: snapshot holds old values
        bus_write(4'h8, 32'h1);
        in_port0 = {32'h0000BEEF, 32'h0BADF00D};
        rd(4'h4, 32'h12345678, "snap0_pre_change");
        rd(4'h5, 32'h0000CAFE, "snap1_pre_change");
        rd(4'h9, 32'h1, "status_valid");
        rd(4'h8, 32'h0, "control_reads_zero");
        rd1(4'h4, 32'h000000A5, "n1_snap0");
        rd1(4'h5, 32'h0, "n1_snap1_absent");
        idle(2);
        rd(4'h0, 32'h0BADF00D, "live_ch0_new");
        rd(4'h1, 32'h0000BEEF, "live_ch1_new");

        // Second trigger sets overrun and overwrites snapshot; W1C
        bus_write(4'h8, 32'h1);
        rd(4'h9, 32'h3, "status_overrun");
        rd(4'h4, 32'h0BADF00D, "snap0_overwritten");
        bus_write(4'h9, 32'h3);
        rd(4'h9, 32'h0, "status_w1c_both");
        bus_write(4'h8, 32'h2);
        rd(4'h9, 32'h0, "control_bit1_no_trigger");
        bus_write(4'h8, 32'h1);
        bus_write(4'h8, 32'h1);
        bus_write(4'h9, 32'h1);
        rd(4'h9, 32'h2, "status_w1c_valid_only");
        bus_write(4'h9, 32'h2);
        rd(4'h9, 32'h0, "status_w1c_overrun");

        // Edge capture and masked interrupt on ch1
        bus_write(4'hB, 32'h3);
        rd(4'hB, 32'h0, "edge_w1c_all");
        bus_write(4'hA, 32'h2);
        rd(4'hA, ie(32'h2), "irq_mask_rw");
        in_port0[32] = ~in_port0[32];
        exp_irq(3, 1'b0, "irq_not_early");
        exp_irq(4, IRQ_EN, "irq_assert");
        idle(6);
        rd(4'hB, ie(32'h2), "edge_ch1_set");
        exp_irq(1, IRQ_EN, "irq_hold_before_clear");
        exp_irq(2, 1'b0, "irq_clear_after_w1c");
        bus_write(4'hB, 32'h2);
        rd(4'hB, 32'h0, "edge_cleared");

        // New change coinciding with W1C keeps the bit set
        in_port0[32] = ~in_port0[32];
        idle(6);
        in_port0[32] = ~in_port0[32];
        idle(2);
        bus_write(4'hB, 32'h2);
        exp_irq(1, IRQ_EN, "irq_stays_set");
        rd(4'hB, ie(32'h2), "edge_set_beats_w1c");
        idle(2);

        // Mask gating of irq
        exp_irq(1, IRQ_EN, "irq_before_mask_off");
        exp_irq(2, 1'b0, "irq_mask_off");
        bus_write(4'hA, 32'h0);
        exp_irq(2, IRQ_EN, "irq_mask_on");
        bus_write(4'hA, 32'h3);
        idle(2);

        // Reset mid-capture with a coincident trigger
        bus_write(4'h8, 32'h1);
        in_port0 = {32'h00001111, 32'h22222222};
        reset = 1'b1;
        exp_irq(1, 1'b0, "irq_cleared_by_reset");
        bus_write(4'h8, 32'h1);
        rd(4'h0, 32'h0, "readdata_in_reset");
        idle(1);
        reset = 1'b0;
        idle(5);
        exp_irq(1, 1'b0, "irq_no_spurious");
        rd(4'h4, 32'h0, "snap_after_reset");
        rd(4'h9, 32'h0, "status_after_reset");
        rd(4'hA, 32'h0, "mask_after_reset");
        rd(4'hB, 32'h0, "edge_no_spurious");
        rd(4'h0, 32'h22222222, "live_after_reset");
        idle(3);

        n_tests++;
        if (readdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL final_unmapped_dut0: got 0x%08h", readdata0);
        end
        n_tests++;
        if (readdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL final_unmapped_dut1: got 0x%08h", readdata1);
        end
        n_tests++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL final_irq0_quiet: got %b", irq0);
        end
        n_tests++;
        if (irq1 !== 1'b0) begin
            n_fail++;
            $display("FAIL final_irq1_quiet: got %b", irq1);
        end

        for (int i = 0; i < due_q.size(); i++) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never checked, expected 0x%08h", name_q[i], exp_q[i]);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
